// File: rtl/tone_arbiter.sv
// tone_arbiter: fixed-priority, non-preemptive arbiter that lets several note
// sources share one tone generator. The granted note plays for its beat count,
// then an optional silent gap follows before the next grant.
`timescale 1ns/1ps
module tone_arbiter #(
  parameter int N_REQ       = 3,
  parameter int PER_W       = 20,
  parameter int DUR_W       = 4,
  parameter int TICK_CYCLES = 12_500_000,
  parameter int GAP_TICKS   = 1,
  localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*PER_W-1:0]   req_period,
  input  logic [N_REQ*DUR_W-1:0]   req_beats,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     stop,
  output logic [PER_W-1:0]         tone_period,
  output logic                     busy,
  output logic [ID_W-1:0]          grant_id,
  output logic                     done,
  output logic [ID_W-1:0]          done_id
);

  localparam int CNT_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int GAP_BITS = $clog2(GAP_TICKS + 1);
  // The remaining-beat counter doubles as the gap beat counter, so it must hold both.
  localparam int REM_W    = (DUR_W > GAP_BITS) ? DUR_W : GAP_BITS;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [PER_W-1:0]    period_q, period_d;
  logic [ID_W-1:0]     grant_q, grant_d;

  logic                beat_tick;
  logic                any_valid;
  logic [ID_W-1:0]     sel_id;
  logic [PER_W-1:0]    sel_period;
  logic [DUR_W-1:0]    sel_beats;
  logic [N_REQ-1:0]    ready_c;
  logic                done_c;

  assign beat_tick = (cnt_q == CNT_MAX);

  // Priority encoder: scan from the top so the lowest valid index wins.
  always_comb begin
    any_valid  = 1'b0;
    sel_id     = '0;
    sel_period = '0;
    sel_beats  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any_valid  = 1'b1;
        sel_id     = ID_W'(i);
        sel_period = req_period[i*PER_W +: PER_W];
        sel_beats  = req_beats[i*DUR_W +: DUR_W];
      end
    end
  end

  // Next-state logic: grant in IDLE, count beats in PLAY and GAP, stop aborts anywhere.
  always_comb begin
    state_d  = state_q;
    cnt_d    = beat_tick ? '0 : cnt_q + CNT_W'(1);
    rem_d    = rem_q;
    period_d = period_q;
    grant_d  = grant_q;
    ready_c  = '0;
    done_c   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!stop && any_valid) begin
          ready_c[sel_id] = 1'b1;
          period_d        = sel_period;
          grant_d         = sel_id;
          rem_d           = (sel_beats == '0) ? REM_W'(1) : REM_W'(sel_beats);
          state_d         = PLAY;
        end
      end
      PLAY: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
          rem_d   = '0;
        end else if (beat_tick) begin
          if (rem_q <= REM_W'(1)) begin
            done_c = 1'b1;
            cnt_d  = '0;
            if (GAP_TICKS > 0) begin
              state_d = GAP;
              rem_d   = REM_W'(GAP_TICKS);
            end else begin
              state_d = IDLE;
              rem_d   = '0;
            end
          end else begin
            rem_d = rem_q - REM_W'(1);
          end
        end
      end
      GAP: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
          rem_d   = '0;
        end else if (beat_tick) begin
          if (rem_q <= REM_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - REM_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        rem_d   = '0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      period_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      period_q <= period_d;
      grant_q  <= grant_d;
    end
  end

  // Ready is suppressed while rst is held so no source believes it was accepted.
  assign req_ready   = rst ? '0 : ready_c;
  assign tone_period = (state_q == PLAY) ? period_q : '0;
  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_q;
  assign done        = done_c;
  assign done_id     = done_c ? grant_q : '0;

endmodule

// File: tb/tb_tone_arbiter.sv
// Self-checking bench for tone_arbiter with short beats (4 cycles) and a one-beat gap.
// Accepted notes are queued as expectations; a monitor pops them on each done pulse.
`timescale 1ns/1ps
module tb_tone_arbiter;

  localparam int N_REQ = 3;
  localparam int PER_W = 20;
  localparam int DUR_W = 4;
  localparam int TICK  = 4;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*PER_W-1:0] req_period;
  logic [N_REQ*DUR_W-1:0] req_beats;
  logic [N_REQ-1:0]       req_ready;
  logic                   stop;
  logic [PER_W-1:0]       tone_period;
  logic                   busy;
  logic [1:0]             grant_id;
  logic                   done;
  logic [1:0]             done_id;

  typedef struct {
    int id;
    int per;
    int len;
  } exp_t;

  exp_t sb[$];
  int   totalChecks = 0;
  int   badChecks   = 0;
  int   cycleCount  = 0;
  int   acceptCycle = 0;
  int   doneCount;

  tone_arbiter #(
    .N_REQ(N_REQ), .PER_W(PER_W), .DUR_W(DUR_W),
    .TICK_CYCLES(TICK), .GAP_TICKS(1)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_period(req_period), .req_beats(req_beats),
    .req_ready(req_ready), .stop(stop),
    .tone_period(tone_period), .busy(busy), .grant_id(grant_id),
    .done(done), .done_id(done_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int id, input int per, input int beats);
    req_valid[id]                 = 1'b1;
    req_period[id*PER_W +: PER_W] = PER_W'(per);
    req_beats[id*DUR_W +: DUR_W]  = DUR_W'(beats);
  endtask

  task automatic clearRequest(input int id);
    req_valid[id] = 1'b0;
  endtask

  task automatic pushExpect(input int id, input int per, input int beats);
    exp_t e;
    e.id  = id;
    e.per = per;
    e.len = ((beats == 0) ? 1 : beats) * TICK;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    #1;
    checkOutput("idle_wait", busy, 0);
  endtask

  // Monitor: note accepts start a timer; every done pulse is matched against the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (|req_ready) acceptCycle = cycleCount;
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("sb_unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("sb_done_id", done_id, e.id);
          checkOutput("sb_period", tone_period, e.per);
          checkOutput("sb_length", cycleCount - acceptCycle, e.len);
        end
      end
    end
    cycleCount++;
  end

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_period = '0;
    req_beats  = '0;
    stop       = 1'b0;
    #2;
    checkOutput("rst_tone", tone_period, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_grant", grant_id, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_done_id", done_id, 0);
    checkOutput("rst_ready", req_ready, 0);
    step();
    rst = 1'b0;
    step();

    // Single note from requester 1: 2 beats then one gap beat.
    $display("[TB] single note");
    applyStimulus(1, 100, 2);
    pushExpect(1, 100, 2);
    #1;
    checkOutput("t1_ready", req_ready, 3'b010);
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k == 1) clearRequest(1);
      #1;
      if (k <= 8) checkOutput("t1_tone", tone_period, 100);
      if (k == 7) checkOutput("t1_done_early", done, 0);
      if (k == 8) begin
        checkOutput("t1_done", done, 1);
        checkOutput("t1_done_id", done_id, 1);
      end
      if (k >= 9 && k <= 12) begin
        checkOutput("t1_gap_tone", tone_period, 0);
        checkOutput("t1_gap_busy", busy, 1);
      end
      if (k == 13) checkOutput("t1_idle", busy, 0);
    end

    // Simultaneous requests 0 and 2: 0 first, 2 after 0's gap.
    $display("[TB] priority");
    step();
    applyStimulus(0, 200, 1);
    applyStimulus(2, 300, 1);
    pushExpect(0, 200, 1);
    pushExpect(2, 300, 1);
    #1;
    checkOutput("t2_ready0", req_ready, 3'b001);
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 1) clearRequest(0);
      #1;
      if (k == 1) checkOutput("t2_tone0", tone_period, 200);
      if (k == 1 || k == 5 || k == 8) checkOutput("t2_ready_busy", req_ready, 0);
      if (k == 9) checkOutput("t2_ready2", req_ready, 3'b100);
    end
    step();
    clearRequest(2);
    #1;
    checkOutput("t2_tone2", tone_period, 300);
    checkOutput("t2_grant2", grant_id, 2);
    waitIdle(60);

    // Requester 0 arrives mid-note of requester 2 and must wait.
    $display("[TB] non-preemption");
    step();
    applyStimulus(2, 400, 3);
    pushExpect(2, 400, 3);
    #1;
    checkOutput("t3_ready2", req_ready, 3'b100);
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 1) clearRequest(2);
      if (k == 3) begin
        applyStimulus(0, 500, 1);
        pushExpect(0, 500, 1);
      end
      #1;
      if (k == 3 || k == 10 || k == 14) checkOutput("t3_no_preempt", req_ready, 0);
      if (k == 11) checkOutput("t3_tone2", tone_period, 400);
      if (k == 12) begin
        checkOutput("t3_done", done, 1);
        checkOutput("t3_done_id", done_id, 2);
      end
      if (k == 17) checkOutput("t3_ready0", req_ready, 3'b001);
    end
    step();
    clearRequest(0);
    #1;
    checkOutput("t3_tone0", tone_period, 500);
    waitIdle(60);

    // Zero-beat rest: plays as one silent beat, pulses done once, then gaps.
    $display("[TB] zero beats rest");
    step();
    applyStimulus(1, 0, 0);
    pushExpect(1, 0, 0);
    #1;
    checkOutput("t4_ready", req_ready, 3'b010);
    doneCount = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 1) clearRequest(1);
      #1;
      doneCount += int'(done);
      if (k == 2) begin
        checkOutput("t4_tone", tone_period, 0);
        checkOutput("t4_busy", busy, 1);
      end
      if (k == 4) checkOutput("t4_done", done, 1);
      if (k == 5) checkOutput("t4_gap_busy", busy, 1);
      if (k == 9) begin
        checkOutput("t4_idle", busy, 0);
        checkOutput("t4_done_count", doneCount, 1);
      end
    end

    // stop on the third PLAY cycle aborts without done; next request accepted at once.
    $display("[TB] stop");
    step();
    applyStimulus(0, 600, 3);
    pushExpect(0, 600, 3);
    #1;
    checkOutput("t5_ready", req_ready, 3'b001);
    step();
    clearRequest(0);
    step();
    step();
    stop = 1'b1;
    #1;
    checkOutput("t5_tone_before", tone_period, 600);
    step();
    stop = 1'b0;
    void'(sb.pop_back());
    applyStimulus(2, 700, 1);
    pushExpect(2, 700, 1);
    #1;
    checkOutput("t5_tone_after", tone_period, 0);
    checkOutput("t5_busy_after", busy, 0);
    checkOutput("t5_done_after", done, 0);
    checkOutput("t5_ready_next", req_ready, 3'b100);
    step();
    clearRequest(2);
    #1;
    checkOutput("t5_tone_next", tone_period, 700);
    waitIdle(60);

    // Async reset between edges mid-PLAY; the held request is re-accepted after release.
    $display("[TB] async reset");
    step();
    applyStimulus(1, 800, 2);
    pushExpect(1, 800, 2);
    #1;
    checkOutput("t6_ready", req_ready, 3'b010);
    step();
    step();
    #2;
    rst = 1'b1;
    void'(sb.pop_back());
    #1;
    checkOutput("t6_rst_tone", tone_period, 0);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_grant", grant_id, 0);
    checkOutput("t6_rst_ready", req_ready, 0);
    checkOutput("t6_rst_done", done, 0);
    step();
    #1;
    rst = 1'b0;
    pushExpect(1, 800, 2);
    #1;
    checkOutput("t6_reaccept", req_ready, 3'b010);
    step();
    clearRequest(1);
    #1;
    checkOutput("t6_tone", tone_period, 800);
    checkOutput("t6_grant", grant_id, 1);
    waitIdle(60);

    step();
    step();
    checkOutput("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
